hazard_sequencer: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline (F,D,E,M,W).
//  - Merges four hazard sources into per-stage Stall/Flush controls: load-use, taken branch/jump in E,

---
 rtl/hazard_sequencer.sv | 143 ++++++++++++++
 tb/tb_hazard_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: central stall/flush scheduler for the F/D/E/M/W pipeline.
// Merges four hazards: load-use, taken branch in E, multi-cycle MDU op in E,
// and data-memory wait in M. It also owns the MDU occupancy FSM.
// Optional feature macro: HAZARD_PERF_CNT_EN, which adds per-hazard perf counters.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | no MDU op in flight; an MduStartE launches one
// MDU   | MDU op occupies E; cnt counts down the remaining stall cycles
module hazard_sequencer #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ResultSrcE,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RD_E,
  input  logic             PCSrcE,
  input  logic             MduStartE,
  input  logic             MemReqM,
  input  logic             DmemReady,
  input  logic             PerfClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             MduBusy,
  output logic             MduDoneE,
  output logic [CNT_W-1:0] LwStallCnt,
  output logic [CNT_W-1:0] MduStallCnt,
  output logic [CNT_W-1:0] MemStallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

  typedef enum logic {RUN, MDU} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic lw_hit, mem_wait, mdu_stall;
  logic act_mem, act_mdu, act_br, act_lw;
  logic done_raw;
  logic [7:0] ctrl;

  assign lw_hit   = ResultSrcE & (RD_E != 5'd0) & ((RS1_D == RD_E) | (RS2_D == RD_E));
  assign mem_wait = MemReqM & ~DmemReady;

  // State and countdown register; reset aborts any MDU op in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic and prioritised stall/flush decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_raw  = 1'b0;
    mdu_stall = ((state == RUN) & MduStartE) | ((state == MDU) & (cnt != '0));
    ctrl      = 8'b0;

    // A memory wait freezes the MDU sequence along with the pipeline.
    if (!mem_wait) begin
      case (state)
        RUN: begin
          if (MduStartE) begin
            state_nxt = MDU;
            cnt_nxt   = CW'(MDU_LAT - 2);
          end
        end
        MDU: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CW'(1);
          end else begin
            state_nxt = RUN;
            done_raw  = 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end

    // ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}
    if (mem_wait)       ctrl = 8'b1111_0001;
    else if (mdu_stall) ctrl = 8'b1110_0010;
    else if (PCSrcE)    ctrl = 8'b0000_1100;
    else if (lw_hit)    ctrl = 8'b1100_0100;
    else                ctrl = 8'b0000_0000;
  end

  assign act_mem = mem_wait;
  assign act_mdu = ~mem_wait & mdu_stall;
  assign act_br  = ~mem_wait & ~mdu_stall & PCSrcE;
  assign act_lw  = ~mem_wait & ~mdu_stall & ~PCSrcE & lw_hit;

  // While reset is held, every output reads 0, whatever the inputs are.
  assign {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW} = rst ? ctrl : 8'b0;
  assign MduBusy  = rst & (state == MDU);
  assign MduDoneE = rst & done_raw;

`ifdef HAZARD_PERF_CNT_EN
  // Wrap-around hazard counters. A clear takes priority over an increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LwStallCnt  <= '0;
      MduStallCnt <= '0;
      MemStallCnt <= '0;
      FlushCnt    <= '0;
    end else if (PerfClr) begin
      LwStallCnt  <= '0;
      MduStallCnt <= '0;
      MemStallCnt <= '0;
      FlushCnt    <= '0;
    end else begin
      if (act_lw)  LwStallCnt  <= LwStallCnt  + CNT_W'(1);
      if (act_mdu) MduStallCnt <= MduStallCnt + CNT_W'(1);
      if (act_mem) MemStallCnt <= MemStallCnt + CNT_W'(1);
      if (act_br)  FlushCnt    <= FlushCnt    + CNT_W'(1);
    end
  end
`else
  logic perf_unused;
  assign perf_unused = PerfClr ^ act_lw ^ act_mdu ^ act_mem ^ act_br;
  assign LwStallCnt  = '0;
  assign MduStallCnt = '0;
  assign MemStallCnt = '0;
  assign FlushCnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Testbench for hazard_sequencer. It runs directed scenarios first, then randomized
// stimulus. All results are checked against a cycle-level reference model.
module tb_hazard_sequencer;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ResultSrcE = 0, PCSrcE = 0, MduStartE = 0, MemReqM = 0, DmemReady = 0, PerfClr = 0;
  logic [4:0] RS1_D = 0, RS2_D = 0, RD_E = 0;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MduBusy, MduDoneE;
  logic [CNT_W-1:0] LwStallCnt, MduStallCnt, MemStallCnt, FlushCnt;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  // m_elapsed counts the non-frozen cycles since the MDU op started.
  bit          m_busy    = 0;
  int          m_elapsed = 0;
  int          m_case    = 5;
  bit          m_mw      = 0;
  logic [31:0] m_cnt [4];   // lw, mdu, mem, flush

  hazard_sequencer #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ResultSrcE(ResultSrcE), .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_E(RD_E),
    .PCSrcE(PCSrcE), .MduStartE(MduStartE), .MemReqM(MemReqM), .DmemReady(DmemReady),
    .PerfClr(PerfClr), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW), .MduBusy(MduBusy),
    .MduDoneE(MduDoneE), .LwStallCnt(LwStallCnt), .MduStallCnt(MduStallCnt),
    .MemStallCnt(MemStallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_elapsed = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = '0;
  endtask

  // Predict this cycle's outputs from the current inputs and compare them with the DUT.
  task automatic model_check();
    bit lw, ms, done;
    logic [9:0] exp_v, got_v;
    m_mw = MemReqM && !DmemReady;
    lw   = ResultSrcE && (RD_E != 0) && (RS1_D == RD_E || RS2_D == RD_E);
    ms   = (!m_busy && MduStartE) || (m_busy && m_elapsed < MDU_LAT - 1);
    done = m_busy && (m_elapsed == MDU_LAT - 1) && !m_mw;
    m_case = m_mw ? 1 : ms ? 2 : PCSrcE ? 3 : lw ? 4 : 5;
    case (m_case)
      1: exp_v[9:2] = 8'b1111_0001;
      2: exp_v[9:2] = 8'b1110_0010;
      3: exp_v[9:2] = 8'b0000_1100;
      4: exp_v[9:2] = 8'b1100_0100;
      default: exp_v[9:2] = 8'b0;
    endcase
    exp_v[1] = m_busy;
    exp_v[0] = done;
    got_v = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MduBusy, MduDoneE};
    chk("ctrl", 64'(got_v), 64'(exp_v));
    chk("no_stall_flush_overlap",
        64'({StallD & FlushD, StallE & FlushE, StallM & FlushM}), 64'(0));
    chk("cnt_lw",    64'(LwStallCnt),  64'(m_cnt[0]));
    chk("cnt_mdu",   64'(MduStallCnt), 64'(m_cnt[1]));
    chk("cnt_mem",   64'(MemStallCnt), 64'(m_cnt[2]));
    chk("cnt_flush", 64'(FlushCnt),    64'(m_cnt[3]));
  endtask

  // Apply the upcoming clock edge to the model.
  task automatic model_advance();
    if (!m_mw) begin
      if (!m_busy) begin
        if (MduStartE) begin
          m_busy = 1;
          m_elapsed = 1;
        end
      end else if (m_elapsed == MDU_LAT - 1) begin
        m_busy = 0;
      end else begin
        m_elapsed++;
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    if (PerfClr) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = '0;
    end else begin
      case (m_case)
        4: m_cnt[0] = m_cnt[0] + 1;
        2: m_cnt[1] = m_cnt[1] + 1;
        1: m_cnt[2] = m_cnt[2] + 1;
        3: m_cnt[3] = m_cnt[3] + 1;
        default: ;
      endcase
    end
`endif
  endtask

  task automatic step(input logic rse, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rde, input logic pcs, input logic st,
                      input logic mreq, input logic drdy, input logic pclr);
    @(negedge clk);
    ResultSrcE = rse; RS1_D = r1; RS2_D = r2; RD_E = rde; PCSrcE = pcs;
    MduStartE = st; MemReqM = mreq; DmemReady = drdy; PerfClr = pclr;
    assert (!(MduStartE && PCSrcE)) else $error("illegal MduStartE with PCSrcE");
    #1;
    model_check();
    model_advance();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    int n_stall;
    int done_at;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs",
        64'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MduBusy, MduDoneE}),
        64'(0));
    chk("reset_counters", 64'({LwStallCnt, MduStallCnt} | {MemStallCnt, FlushCnt}), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // T1: load-use hazard, then the same load with rd = x0.
    step(1, 0, 5, 5, 0, 0, 0, 1, 0);
    chk("t1_lw_hit", 64'({StallF, StallD, FlushE, StallE}), 64'(4'b1110));
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t1_x0", 64'({StallF, StallD, FlushE}), 64'(0));

    // T2: a plain MDU op stalls for MDU_LAT-1 cycles, then signals done.
    n_stall = 0;
    done_at = -1;
    step(0, 0, 0, 0, 0, 1, 0, 1, 0);
    n_stall += StallE;
    for (int i = 1; i < MDU_LAT + 1; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      n_stall += (StallE && FlushM);
      if (MduDoneE) done_at = i;
    end
    chk("t2_stall_cycles", 64'(n_stall), 64'(MDU_LAT - 1));
    chk("t2_done_cycle", 64'(done_at), 64'(MDU_LAT - 1));

    // T3: a two-cycle memory wait at cnt=1 delays MDU completion.
    step(0, 0, 0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t3_memwait", 64'({StallF, StallD, StallE, StallM, FlushW}), 64'(5'b11111));
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t3_resume_stall", 64'({StallE, FlushM, MduDoneE}), 64'(3'b110));
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t3_done_late", 64'(MduDoneE), 64'(1));

    // T4: a taken branch wins over a load-use hazard.
    step(1, 7, 0, 7, 1, 0, 0, 1, 0);
    chk("t4_branch", 64'({FlushD, FlushE, StallF, StallD}), 64'(4'b1100));

    // T5: asynchronous reset while the MDU op is in flight (cnt=2).
    step(0, 0, 0, 0, 0, 1, 0, 1, 0);
    @(negedge clk);
    MduStartE = 0;
    #1;
    chk("t5_pre_busy", 64'({MduBusy, StallE}), 64'(2'b11));
    #1 rst = 1'b0;
    #1;
    chk("t5_async_zero",
        64'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MduBusy, MduDoneE}),
        64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    chk("t5_run_after", 64'(MduBusy), 64'(0));

    // T6: perf counters (all zero when the counter feature is not built in).
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 3, 0, 3, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 1, 0);
    idle(MDU_LAT - 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, 0);
    idle(1);
`ifdef HAZARD_PERF_CNT_EN
    chk("t6_counts", 64'({LwStallCnt[7:0], MduStallCnt[7:0], MemStallCnt[7:0], FlushCnt[7:0]}),
        64'(32'h01030201));
`else
    chk("t6_counts", 64'({LwStallCnt[7:0], MduStallCnt[7:0], MemStallCnt[7:0], FlushCnt[7:0]}),
        64'(0));
`endif
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    chk("t6_clear", 64'({LwStallCnt[7:0], MduStallCnt[7:0], MemStallCnt[7:0], FlushCnt[7:0]}),
        64'(0));

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic st, pcs;
      st  = ($urandom % 6) == 0;
      pcs = st ? 1'b0 : (($urandom % 6) == 0);
      step(($urandom % 3) == 0, 5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
           pcs, st, ($urandom % 3) == 0, 1'($urandom % 2), ($urandom % 50) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
